// File: rtl/mem_load_ctrl_pkg.sv
// Shared types and constants for the memory-load sequencer.
//   state_t    : sequencer states
//   DEF_*      : default parameter values
//   len_width  : width of a word-count field able to hold 0..max_len
package mem_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 32;
  localparam int DEF_MAX_LEN = 5;
  localparam int DEF_TIMEOUT = 16;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/mem_load_ctrl_if.sv
// Source stream plus memory write port of the load sequencer.
//   din/din_valid/din_ready : valid/ready word source
//   mem_we/mem_addr/mem_wdata : synchronous memory write port
// master: the sequencer side; slave: the source/memory side.
interface mem_load_ctrl_if
  import mem_load_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    input  din, din_valid,
    output din_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output din, din_valid,
    input  din_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_load_ctrl_watchdog.sv
// Stall watchdog: counts consecutive tick cycles, cleared by clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (has priority over tick)
//   tick       : one stall cycle
//   expired    : this tick is the TIMEOUT-th consecutive stall
module load_watchdog
  import mem_load_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = tick && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !expired) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/mem_load_ctrl.sv
// Memory-load sequencer: on start, streams len words from the source
// into consecutive memory addresses starting at base_addr.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, base_addr, len : load command (sampled in IDLE only)
//   busy               : state != IDLE
//   load_mem           : high while loading
//   done               : one-cycle pulse after the last write
//   err                : one-cycle pulse on illegal len or stall timeout
//   bus                : source stream and memory write port
module mem_load_ctrl
  import mem_load_pkg::*;
#(
  parameter  int AW      = DEF_AW,
  parameter  int DW      = DEF_DW,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int LW      = len_width(MAX_LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  input  logic [LW-1:0]  len,
  output logic           busy,
  output logic           load_mem,
  output logic           done,
  output logic           err,
  mem_load_ctrl_if.master bus
);
  state_t        state;
  logic [AW-1:0] base_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [DW-1:0] word;
  logic          accept;
  logic          last;
  logic          len_ok;
  logic          wd_clear;
  logic          wd_tick;
  logic          wd_expired;

  assign word          = bus.din;
  assign bus.din_ready = (state == LOAD);
  assign accept        = bus.din_ready && bus.din_valid;
  assign last          = (idx == len_q - LW'(1));
  assign len_ok        = (len != '0) && (len <= LW'(MAX_LEN));

  // Outside LOAD the counter is held clear, so it starts at zero on entry.
  assign wd_clear = (state != LOAD) || accept;
  assign wd_tick  = (state == LOAD) && !accept;

  load_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .tick    (wd_tick),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      load_mem      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len_ok) begin
              state    <= LOAD;
              base_q   <= base_addr;
              len_q    <= len;
              idx      <= '0;
              load_mem <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        LOAD: begin
          // An accept wins over an expiring watchdog (expired needs a stall).
          if (accept) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= base_q + AW'(idx);
            bus.mem_wdata <= word;
            idx           <= idx + LW'(1);
            if (last) begin
              state    <= DONE;
              load_mem <= 1'b0;
              done     <= 1'b1;
            end
          end else if (wd_expired) begin
            state    <= ERR;
            load_mem <= 1'b0;
            err      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          load_mem <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_load_ctrl.sv
module tb_mem_load_ctrl;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int MAX_LEN = 5;
  localparam int TIMEOUT = 16;

  localparam int K_LM = 0;  // load_mem rising edge
  localparam int K_WR = 1;  // memory write
  localparam int K_DN = 2;  // done pulse
  localparam int K_ER = 3;  // err pulse

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [2:0]    len       = '0;
  logic          busy;
  logic          load_mem;
  logic          done;
  logic          err;

  mem_load_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_load_ctrl #(
    .AW      (AW),
    .DW      (DW),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .load_mem  (load_mem),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  typedef struct {
    int            kind;
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  bit            lm_prev = 1'b0;
  ev_t           exp_q[$];
  logic [DW-1:0] src_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic seen(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d want no event", k, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(k), 64'(e.kind));
      chk("event_cycle", 64'(cyc), 64'(e.cyc));
      if (e.kind == K_WR) begin
        chk("wr_addr", 64'(a), 64'(e.addr));
        chk("wr_data", 64'(d), 64'(e.data));
      end
    end
  endtask

  // Monitor: compares every observed DUT event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lm_prev = 1'b0;
      end else begin
        if (load_mem && !lm_prev) seen(K_LM, '0, '0);
        lm_prev = load_mem;
        if (bus.mem_we) seen(K_WR, bus.mem_addr, bus.mem_wdata);
        if (done) seen(K_DN, '0, '0);
        if (err) seen(K_ER, '0, '0);
      end
    end
  end

  // Source driver: presents the head of src_q; pops it when it will be accepted.
  initial begin
    bus.din_valid = 1'b0;
    bus.din       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && src_q.size() > 0) begin
        bus.din_valid = 1'b1;
        bus.din       = src_q[0];
        if (bus.din_ready) void'(src_q.pop_front());
      end else begin
        bus.din_valid = 1'b0;
      end
    end
  end

  // Returns n = edge count at which start is sampled.
  task automatic issue(input logic [AW-1:0] b, input logic [2:0] l, output int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    len       = l;
    n         = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_src(input logic [DW-1:0] d0, input int cnt);
    for (int i = 0; i < cnt; i++) src_q.push_back(d0 + DW'(i));
  endtask

  task automatic expect_full(input int n, input logic [AW-1:0] b, input int l, input logic [DW-1:0] d0);
    logic [AW-1:0] a;
    push(K_LM, n, '0, '0);
    for (int i = 0; i < l; i++) begin
      a = b + AW'(i);
      push(K_WR, n + 1 + i, a, d0 + DW'(i));
    end
    push(K_DN, n + l, '0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    src_q.delete();
    repeat (6) @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_load_mem"}, 64'(load_mem), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, "_din_ready"}, 64'(bus.din_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish by 100000");
    $fatal(1, "time limit");
  end

  initial begin
    logic [AW-1:0] t_base[4];
    int            t_len[4];
    logic [DW-1:0] t_d0[4];
    logic [2:0]    bad_len[2];
    int            n;

    t_base = '{8'h10, 8'h20, 8'h30, 8'hFE};
    t_len  = '{3, 5, 1, 3};
    t_d0   = '{32'hA000_000A, 32'hB000_0000, 32'hC000_0000, 32'hD000_0000};
    bad_len = '{3'd0, 3'd6};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
    rst_n = 1'b1;

    // Unstalled loads, including len=MAX_LEN, len=1 and address wrap.
    for (int t = 0; t < 4; t++) begin
      load_src(t_d0[t], t_len[t]);
      issue(t_base[t], 3'(t_len[t]), n);
      expect_full(n, t_base[t], t_len[t], t_d0[t]);
      drain();
    end

    // Illegal lengths: err only, busy for the ERR cycle alone.
    for (int t = 0; t < 2; t++) begin
      issue(8'h33, bad_len[t], n);
      push(K_ER, n, '0, '0);
      @(negedge clk);
      chk("illegal_busy_err_cycle", 64'(busy), 64'd1);
      @(negedge clk);
      chk("illegal_busy_after", 64'(busy), 64'd0);
      drain();
    end

    // Stall after two words: watchdog aborts after TIMEOUT stall cycles.
    load_src(32'hE000_0000, 2);
    issue(8'h50, 3'd4, n);
    push(K_LM, n, '0, '0);
    push(K_WR, n + 1, 8'h50, 32'hE000_0000);
    push(K_WR, n + 2, 8'h51, 32'hE000_0001);
    push(K_ER, n + 2 + TIMEOUT, '0, '0);
    drain();
    chk("timeout_back_idle", 64'(busy), 64'd0);

    // Reset in the middle of a load.
    load_src(32'hF000_0000, 1);
    issue(8'h60, 3'd3, n);
    push(K_LM, n, '0, '0);
    push(K_WR, n + 1, 8'h60, 32'hF000_0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midreset_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    src_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain();

    // start while busy is ignored.
    load_src(32'h1234_5670, 3);
    issue(8'h70, 3'd3, n);
    expect_full(n, 8'h70, 3, 32'h1234_5670);
    #1;
    start     = 1'b1;
    base_addr = 8'h40;
    len       = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (10) @(posedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
